hyperbus_cmd_splitter: RTL and testbench

//  Upstream neighbour of hyperbus_phy. Takes one front-end burst request (byte address, word count, r/w, address space)
//  and issues one or more PHY transactions (trans_*), each bounded by MAX_BURST and a row boundary.

---
 rtl/hyperbus_pkg.sv | 41 ++++
 rtl/hyperbus_cmd_splitter.sv | 145 ++++++++++++++
 tb/tb_hyperbus_cmd_splitter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus command-path types: splitter state, PHY transaction bundle,
// and the chunk-size helper used to cut bursts at MAX_BURST and row edges.
package hyperbus_pkg;

    localparam int unsigned HB_NR_CS       = 2;
    localparam int unsigned HB_BURST_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } split_state_e;

    typedef struct packed {
        logic [31:0]               address;
        logic [HB_NR_CS-1:0]       cs;
        logic                      write;
        logic [HB_BURST_WIDTH-1:0] burst;
        logic                      address_space;
    } hyper_trans_t;

    // Words to issue next: limited by what is left, by the PHY burst limit,
    // and by the distance to the next row boundary.
    function automatic logic [31:0] chunk_len(
        input logic [31:0] rem,
        input logic [31:0] waddr,
        input logic [31:0] max_burst,
        input logic [31:0] row_log2
    );
        logic [31:0] row_words;
        logic [31:0] room;
        logic [31:0] c;
        row_words = 32'd1 << row_log2;
        room      = row_words - (waddr & (row_words - 32'd1));
        c         = rem;
        if (max_burst < c) c = max_burst;
        if (room < c)      c = room;
        return c;
    endfunction

endpackage

// File: rtl/hyperbus_cmd_splitter.sv
// Splits one front-end burst request into PHY transactions bounded by
// MAX_BURST and row edges, decodes chip select, rejects illegal requests.
// Ports: req_* (request in), trans_* (PHY command out), rsp_* (completion out).
module hyperbus_cmd_splitter
    import hyperbus_pkg::*;
#(
    parameter int unsigned NR_CS        = HB_NR_CS,
    parameter int unsigned BURST_WIDTH  = HB_BURST_WIDTH,
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned MAX_BURST    = 512,
    parameter int unsigned ROW_LOG2     = 9,
    parameter int unsigned CS_SIZE_LOG2 = 23
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic [LEN_WIDTH-1:0]   req_len_i,
    input  logic                   req_write_i,
    input  logic                   req_addr_space_i,
    output logic                   trans_valid_o,
    input  logic                   trans_ready_i,
    output logic [31:0]            trans_address_o,
    output logic [NR_CS-1:0]       trans_cs_o,
    output logic                   trans_write_o,
    output logic [BURST_WIDTH-1:0] trans_burst_o,
    output logic                   trans_address_space_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_error_o
);

    localparam int unsigned CHIP_W = 32 - CS_SIZE_LOG2;

    split_state_e           state_q, state_d;
    hyper_trans_t           trans_q, trans_d;
    logic [LEN_WIDTH:0]     rem_q, rem_d;
    logic [31:0]            waddr_q, waddr_d;
    logic                   err_q, err_d;

    logic [CHIP_W-1:0]      chip_idx;
    logic [32:0]            span_end;
    logic                   req_err;
    logic [LEN_WIDTH:0]     burst_ext;

    assign chip_idx = req_addr_i[31:CS_SIZE_LOG2];

    // One past the last word touched; must not exceed the chip's word count.
    assign span_end = 33'(req_addr_i[CS_SIZE_LOG2-1:1])
                    + 33'(req_len_i) + 33'd1;

    assign req_err = req_addr_i[0]
                   | (32'(chip_idx) >= NR_CS)
                   | (span_end > (33'd1 << (CS_SIZE_LOG2 - 1)));

    assign burst_ext = (LEN_WIDTH+1)'(trans_q.burst);

    always_comb begin
        state_d = state_q;
        trans_d = trans_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d               = ST_ISSUE;
                        err_d                 = 1'b0;
                        rem_d                 = (LEN_WIDTH+1)'(req_len_i)
                                              + 1'b1;
                        waddr_d               =
                            32'(req_addr_i[CS_SIZE_LOG2-1:1]);
                        trans_d.cs            = NR_CS'(1) << chip_idx;
                        trans_d.write         = req_write_i;
                        trans_d.address_space = req_addr_space_i;
                    end
                end
            end
            ST_ISSUE: begin
                if (trans_ready_i) begin
                    // Register space is always a single 1-word access.
                    if (trans_q.address_space || rem_q == burst_ext) begin
                        state_d = ST_RESP;
                    end else begin
                        rem_d   = rem_q - burst_ext;
                        waddr_d = waddr_q + 32'(trans_q.burst);
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering or staying in ISSUE: (re)derive the pending chunk from
        // the next address/remainder, which is unchanged while stalled.
        if (state_d == ST_ISSUE) begin
            trans_d.address = waddr_d;
            trans_d.burst   = trans_d.address_space
                            ? BURST_WIDTH'(1)
                            : BURST_WIDTH'(chunk_len(32'(rem_d), waddr_d,
                                                     MAX_BURST, ROW_LOG2));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trans_q <= '0;
            rem_q   <= '0;
            waddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            trans_q <= trans_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o           = (state_q == ST_IDLE);
    assign trans_valid_o         = (state_q == ST_ISSUE);
    assign rsp_valid_o           = (state_q == ST_RESP);
    assign rsp_error_o           = err_q;
    assign trans_address_o       = trans_q.address;
    assign trans_cs_o            = trans_q.cs;
    assign trans_write_o         = trans_q.write;
    assign trans_burst_o         = trans_q.burst;
    assign trans_address_space_o = trans_q.address_space;

endmodule

// File: tb/tb_hyperbus_cmd_splitter.sv
// Directed + randomized bench for hyperbus_cmd_splitter against a
// word-level reference model of the request splitting rules.
module tb_hyperbus_cmd_splitter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [15:0] req_len_i;
    logic        req_write_i;
    logic        req_addr_space_i;
    logic        trans_valid_o;
    logic        trans_ready_i;
    logic [31:0] trans_address_o;
    logic [1:0]  trans_cs_o;
    logic        trans_write_o;
    logic [11:0] trans_burst_o;
    logic        trans_address_space_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_error_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [47:0] exp_q[$];
    bit          exp_err;

    always #5 clk_i = ~clk_i;

    hyperbus_cmd_splitter dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_addr_i            (req_addr_i),
        .req_len_i             (req_len_i),
        .req_write_i           (req_write_i),
        .req_addr_space_i      (req_addr_space_i),
        .trans_valid_o         (trans_valid_o),
        .trans_ready_i         (trans_ready_i),
        .trans_address_o       (trans_address_o),
        .trans_cs_o            (trans_cs_o),
        .trans_write_o         (trans_write_o),
        .trans_burst_o         (trans_burst_o),
        .trans_address_space_o (trans_address_space_o),
        .rsp_valid_o           (rsp_valid_o),
        .rsp_ready_i           (rsp_ready_i),
        .rsp_error_o           (rsp_error_o)
    );

    function automatic logic [47:0] trans_vec();
        return {trans_address_o, trans_cs_o, trans_write_o,
                trans_burst_o, trans_address_space_o};
    endfunction

    function automatic logic [51:0] all_vec();
        return {req_ready_o, trans_valid_o, rsp_valid_o, rsp_error_o,
                trans_vec()};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: chip = 8 MiB (4 Mi words), rows of 512 words, max 512/trans.
    task automatic model(input logic [31:0] addr, input int len,
                         input bit wr, input bit as);
        longint w, rem, c, room, chip;
        exp_q.delete();
        chip = addr / 32'h0080_0000;
        w    = (addr % 32'h0080_0000) / 2;
        exp_err = addr[0] || chip >= 2 || (w + len + 1 > 4194304);
        if (exp_err) return;
        rem = len + 1;
        while (rem > 0) begin
            room = 512 - (w % 512);
            c = rem;
            if (c > 512) c = 512;
            if (c > room) c = room;
            if (as) c = 1;
            exp_q.push_back({32'(w), 2'(1 << chip), wr, 12'(c), as});
            if (as) break;
            w   += c;
            rem -= c;
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input int len,
                           input bit wr, input bit as, input int stall_n,
                           input int rsp_hold, input bit rnd);
        int          idx;
        int          stalls;
        bit          held;
        bit          last;
        logic [47:0] snap;
        model(addr, len, wr, as);
        @(negedge clk_i);
        chk("req_ready_idle", 64'(req_ready_o), 64'(1));
        req_valid_i      = 1'b1;
        req_addr_i       = addr;
        req_len_i        = 16'(len);
        req_write_i      = wr;
        req_addr_space_i = as;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        if (exp_err)
            chk("err_latency", {62'd0, trans_valid_o, rsp_valid_o}, 64'd1);
        else
            chk("trans_latency", 64'(trans_valid_o), 64'(1));
        idx = 0; stalls = 0; held = 0; last = 0; snap = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (rsp_valid_o) break;
            if (held) chk("stall_stable", 64'(trans_vec()), 64'(snap));
            held = 0;
            trans_ready_i = 1'b0;
            if (trans_valid_o) begin
                if (idx >= exp_q.size()) begin
                    chk("extra_chunk", 64'(idx), 64'(exp_q.size()));
                    break;
                end
                if (idx == 1 && stalls < stall_n) stalls++;
                else trans_ready_i = rnd ? ($urandom_range(3) != 0) : 1'b1;
                if (trans_ready_i) begin
                    chk($sformatf("trans[%0d]", idx),
                        64'(trans_vec()), 64'(exp_q[idx]));
                    idx++;
                    last = (idx == exp_q.size());
                end else begin
                    held = 1;
                    snap = trans_vec();
                end
            end
            @(negedge clk_i);
            if (last) begin
                chk("rsp_latency", 64'(rsp_valid_o), 64'(1));
                break;
            end
        end
        trans_ready_i = 1'b0;
        chk("rsp_valid", 64'(rsp_valid_o), 64'(1));
        chk("rsp_error", 64'(rsp_error_o), 64'(exp_err));
        chk("chunk_count", 64'(idx), 64'(exp_q.size()));
        for (int k = 0; k < rsp_hold; k++) begin
            @(negedge clk_i);
            chk("rsp_hold", {61'd0, rsp_valid_o, rsp_error_o, req_ready_o},
                {61'd0, 1'b1, exp_err, 1'b0});
        end
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rsp_one_cycle", {62'd0, rsp_valid_o, req_ready_o}, 64'd1);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          l;
        rst_ni           = 1'b0;
        req_valid_i      = 1'b0;
        req_addr_i       = '0;
        req_len_i        = '0;
        req_write_i      = 1'b0;
        req_addr_space_i = 1'b0;
        trans_ready_i    = 1'b0;
        rsp_ready_i      = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_in", 64'(all_vec()), {12'd0, 1'b1, 51'd0});
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_out", 64'(all_vec()), {12'd0, 1'b1, 51'd0});

        run_req(32'h0000_0100,   15, 0, 0, 0, 0, 0);
        run_req(32'h0000_03F8,    9, 1, 0, 0, 0, 0);
        run_req(32'h0000_0000, 1199, 0, 0, 5, 0, 0);
        run_req(32'h0100_0000,    3, 0, 0, 0, 3, 0);
        run_req(32'h0000_0101,    0, 1, 0, 0, 0, 0);
        run_req(32'h007F_FFEC,    9, 0, 0, 0, 0, 0);
        run_req(32'h007F_FFEC,   10, 1, 0, 0, 0, 0);
        run_req(32'h00FF_FFEC,    9, 1, 0, 0, 1, 0);
        run_req(32'h0000_0400,    0, 0, 0, 0, 0, 0);
        run_req(32'h0000_0400,  700, 1, 0, 2, 0, 0);
        run_req(32'h0000_0010,    7, 0, 1, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom & 32'h01FF_FFFE;
            if ($urandom_range(7) == 0) a[0] = 1'b1;
            if ($urandom_range(3) == 0) a[22:12] = 11'h7FF;
            l = int'($urandom_range(1500));
            run_req(a, l, 1'($urandom), ($urandom_range(5) == 0),
                    int'($urandom_range(3)), int'($urandom_range(2)), 1);
        end

        // Async reset while a transaction is pending.
        @(negedge clk_i);
        req_valid_i      = 1'b1;
        req_addr_i       = 32'h0000_0000;
        req_len_i        = 16'd2000;
        req_addr_space_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("pre_reset_issue", 64'(trans_valid_o), 64'(1));
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 chk("reset_mid_issue", 64'(all_vec()), {12'd0, 1'b1, 51'd0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        trans_ready_i = 1'b1;
        rsp_ready_i   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("no_rsp_after_reset", 64'(all_vec()), {12'd0, 1'b1, 51'd0});
        end
        trans_ready_i = 1'b0;
        rsp_ready_i   = 1'b0;
        run_req(32'h0080_0010, 5, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
